load_align_unit: RTL
====================

# load_align_unit

Multi-cycle load-data unit between the pipeline's memory stage and the data-memory bus. It accepts a load request, issues one or two aligned bus reads, then merges, extracts and sign- or zero-extends the addressed bytes. It generalises fixed 32-bit byte-lane extraction to an XLEN-wide datapath (RV32/RV64 loads, including LD and LWU). It also handles accesses that cross an XLEN boundary as two bus beats, with an optional misaligned-fault mode.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing loads into two beats; 0 = fault them.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_funct3  in  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- mem_req_valid  out  1  bus read request.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  ADDR_W  read address, aligned to XLEN/8.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read data, little-endian.
- rsp_valid  out  1  load result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  XLEN  extended load result.
- rsp_fault  out  1  illegal width or misaligned fault; qualified by rsp_valid.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid && req_ready, register the address, funct3, offset = addr[log2(XLEN/8)-1:0] and size (1/2/4/8 bytes).
  - Illegal funct3 (111 always; 011 or 110 when XLEN=32): go to RESP with rsp_fault=1 and rsp_data=0. No bus access.
  - Crossing (offset + size > XLEN/8) with MISALIGN_EN=0: same fault path.
  - Otherwise go to REQ0.
- REQ0: drive mem_req_valid=1 and mem_req_addr = addr with the low offset bits cleared. On mem_req_ready go to WAIT0.
- WAIT0: on mem_rsp_valid, capture the data as beat0. Go to REQ1 if the access crosses, else RESP.
- REQ1: mem_req_addr = beat0 address + XLEN/8, wrapping modulo 2^ADDR_W. On mem_req_ready go to WAIT1.
- WAIT1: on mem_rsp_valid, capture the data as beat1 and go to RESP.
- Merge rule: form the 2*XLEN value {beat1, beat0}, with beat1=0 for single-beat accesses. Shift right by offset*8 and take the low size*8 bits.
  - Signed funct3 (000/001/010/011): sign-extend from the top extracted bit to XLEN.
  - Unsigned funct3 (100/101/110): zero-extend.
  - LD on XLEN=64 returns the merged value unchanged.
- RESP: hold rsp_valid, rsp_data and rsp_fault stable until rsp_ready. On handshake go to IDLE.
- At most one outstanding bus read. mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- mem_req_valid, once raised, stays high with a stable address until mem_req_ready.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE.
  - req_ready=1, mem_req_valid=0, mem_req_addr=0.
  - rsp_valid=0, rsp_data=0, rsp_fault=0.
  - Captured beats cleared.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Request accepted in cycle T: mem_req_valid is high in T+1.
  - With zero-wait bus (mem_req_ready in T+1, mem_rsp_valid in T+2): rsp_valid high in T+3 for single-beat accesses, T+5 for two-beat accesses.
  - Fault path: rsp_valid high in T+1.
- req_ready is low from T+1 until the cycle after the rsp handshake, so back-to-back requests are spaced at least one IDLE cycle apart.
- Reset mid-transaction aborts it. An in-flight bus response arriving after reset is ignored (state IDLE).

## Test plan
- XLEN=32, LB at 0x1003, bus word 0x80FF_1234 → a single read at 0x1000; rsp_data=0xFFFF_FF80, rsp_fault=0. The same access as LBU → 0x0000_0080.
- LHU at 0x1002, bus word 0xBEEF_0000 → rsp_data=0x0000_BEEF. LH at 0x1002 with the same word → 0xFFFF_BEEF.
- MISALIGN_EN=1, LW at 0x1002, beats 0x4433_2211 (0x1000) and 0x8877_6655 (0x1004) → two reads in order; rsp_data=0x6655_4433. LH at 0x1003 with the same beats → 0x0000_5544. LW at 0xFFFF_FFFE → reads at 0xFFFF_FFFC then 0x0000_0000.
- MISALIGN_EN=0, LW at 0x1001 → no mem_req_valid; rsp_valid in the cycle after acceptance with rsp_fault=1 and rsp_data=0. funct3=011 at XLEN=32 → the same fault response.
- XLEN=64, LD at 0x2004, beats 0x8877_6655_4433_2211 and 0x0000_0000_CCBB_AA99 → rsp_data=0xCCBB_AA99_8877_6655. LWU at 0x2004 with beat0 only → 0x0000_0000_8877_6655.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles → rsp_valid and rsp_data stay stable, and req_ready stays 0.
  - Assert rst_n=0 in WAIT1 → all outputs take their reset values immediately. After release, a late mem_rsp_valid is ignored and req_ready=1.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: issues one or two aligned bus reads per load, then merges,
// extracts and sign/zero-extends the addressed bytes into an XLEN result.
module load_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_fault
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            r_state;
  logic [OW-1:0]     r_off;
  logic [2:0]        r_f3;
  logic              r_cross;
  logic [XLEN-1:0]   r_beat0;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_rsp_fault;

  logic [OW-1:0] w_off;
  logic [3:0]    w_size;
  logic          w_cross;
  logic          w_illegal;
  logic          w_fault;

  assign w_off     = req_addr[OW-1:0];
  assign w_size    = 4'd1 << req_funct3[1:0];
  assign w_cross   = (5'(w_off) + 5'(w_size)) > 5'(NB);
  assign w_illegal = (req_funct3 == 3'b111) ||
                     ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
  assign w_fault   = w_illegal || (w_cross && !MISALIGN_EN);

  assign req_ready     = r_state == IDLE;
  assign mem_req_valid = (r_state == REQ0) || (r_state == REQ1);
  assign mem_req_addr  = r_mem_addr;
  assign rsp_valid     = r_state == RESP;
  assign rsp_data      = r_rsp_data;
  assign rsp_fault     = r_rsp_fault;

  // Mask keeps the low size*8 bits; the mask's top bit selects the sign bit.
  function automatic logic [XLEN-1:0] f_ext(input logic [2*XLEN-1:0] m,
                                           input logic [OW-1:0] off,
                                           input logic [2:0] f3);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   mask;
    logic              sgn;
    sh   = m >> {off, 3'b000};
    lo   = sh[XLEN-1:0];
    mask = {XLEN{1'b1}} >> (7'(XLEN) - (7'd8 << f3[1:0]));
    sgn  = ~f3[2] & |(lo & (mask ^ (mask >> 1)));
    return (lo & mask) | ({XLEN{sgn}} & ~mask);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_off       <= '0;
      r_f3        <= '0;
      r_cross     <= 1'b0;
      r_beat0     <= '0;
      r_mem_addr  <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_off       <= w_off;
          r_f3        <= req_funct3;
          r_cross     <= w_cross;
          r_rsp_data  <= '0;
          r_rsp_fault <= w_fault;
          r_mem_addr  <= w_fault ? r_mem_addr : {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
          r_state     <= w_fault ? RESP : REQ0;
        end
        REQ0, REQ1: if (mem_req_ready) r_state <= (r_state == REQ0) ? WAIT0 : WAIT1;
        WAIT0: if (mem_rsp_valid) begin
          r_beat0 <= mem_rsp_data;
          if (r_cross) begin
            r_mem_addr <= r_mem_addr + ADDR_W'(NB);
            r_state    <= REQ1;
          end else begin
            r_rsp_data <= f_ext({{XLEN{1'b0}}, mem_rsp_data}, r_off, r_f3);
            r_state    <= RESP;
          end
        end
        WAIT1: if (mem_rsp_valid) begin
          r_rsp_data <= f_ext({mem_rsp_data, r_beat0}, r_off, r_f3);
          r_state    <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
